// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply (shift-add) / divide (restoring) unit, one step per cycle.
// Optional two's-complement support is enabled with `define MULDIV_SIGNED_EN.
module mul_div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] r0_data_o,
  output logic             r0_write_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] r0_q, r0_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]     sum, sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               accept;

`ifdef MULDIV_SIGNED_EN
  // neg_res: quotient/product sign; neg_rem: remainder sign (follows dividend)
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic a_neg, b_neg;

  assign a_neg = sgn_i & a_i[WIDTH-1];
  assign b_neg = sgn_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  assign accept = start_i && (state_q != StRun);

  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    sh      = {hi_q, lo_q[WIDTH-1]};
    diff    = sh - {1'b0, opnd_q};
    ge      = (sh >= {1'b0, opnd_q});
    if (op_q) begin
      step_hi = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
    prod    = {step_hi, step_lo};
    fin_hi  = step_hi;
    fin_lo  = step_lo;
`ifdef MULDIV_SIGNED_EN
    if (op_q) begin
      if (neg_res_q) fin_lo = -step_lo;
      if (neg_rem_q) fin_hi = -step_hi;
    end else if (neg_res_q) begin
      prod   = -prod;
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_lo_d = res_lo_q;
    r0_d     = r0_q;
    dz_d     = dz_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      StRun: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          res_lo_d = fin_lo;
          r0_d     = fin_hi;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      op_d   = op_i;
      cnt_d  = '0;
      opnd_d = b_mag;
      hi_d   = '0;
      lo_d   = a_mag;
      dz_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
`endif
      if (op_i && (b_i == '0)) begin
        // divide by zero skips the iteration entirely
        state_d  = StDone;
        res_lo_d = '1;
        r0_d     = a_i;
        dz_d     = 1'b1;
      end else begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_lo_q <= '0;
      r0_q     <= '0;
      dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_lo_q <= res_lo_d;
      r0_q     <= r0_d;
      dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign r0_write_o = (state_q == StDone);
  assign res_lo_o   = res_lo_q;
  assign r0_data_o  = r0_q;
  assign div_zero_o = dz_q;

endmodule
